ldpc_iter_ctrl: RTL and testbench

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

---
 rtl/ldpc_iter_ctrl_if.sv | 41 ++++
 rtl/ldpc_iter_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_iter_ctrl_if.sv
// Signal bundle between the LDPC iteration controller and its environment
// (host, q-memory unit and check-node unit). The controller uses the slave
// modport; the environment side uses master.
interface ldpc_iter_ctrl_if;
  // Host requests
  logic       frame_start;
  logic       abort;
  // Status from the q-memory unit and check-node unit
  logic       finish_bubble_sort;
  logic       f_one_iteration;
  logic       last_iteration;
  logic       cu_done;
  logic       syndrome_ok;
  // Control strobes towards the datapath
  logic       start_q_unit;
  logic       rst_q_unit;
  logic       en_bubble_sort;
  logic       storage;
  logic       cu_start;
  // Progress and result reporting
  logic [3:0] layer_idx;
  logic [4:0] iter_cnt;
  logic       busy;
  logic       frame_done;
  logic       decode_ok;
  logic       seq_err;

  modport master (
    output frame_start, abort, finish_bubble_sort, f_one_iteration,
           last_iteration, cu_done, syndrome_ok,
    input  start_q_unit, rst_q_unit, en_bubble_sort, storage, cu_start,
           layer_idx, iter_cnt, busy, frame_done, decode_ok, seq_err
  );

  modport slave (
    input  frame_start, abort, finish_bubble_sort, f_one_iteration,
           last_iteration, cu_done, syndrome_ok,
    output start_q_unit, rst_q_unit, en_bubble_sort, storage, cu_start,
           layer_idx, iter_cnt, busy, frame_done, decode_ok, seq_err
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// Layered LDPC decoder iteration controller. Sequences one frame through
// channel load, index sort, then per-layer check-node processing and
// write-back until the syndrome is satisfied or the q-memory unit reports
// the iteration cap. All control outputs come straight from flops.
module ldpc_iter_ctrl #(
  parameter int NUM_LAYERS = 16,
  parameter int MAX_ITER   = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  ldpc_iter_ctrl_if.slave bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_SORT     = 4'd2;
  localparam logic [3:0] S_LAYER    = 4'd3;
  localparam logic [3:0] S_WAIT     = 4'd4;
  localparam logic [3:0] S_STORE    = 4'd5;
  localparam logic [3:0] S_ITER_END = 4'd6;
  localparam logic [3:0] S_EVAL     = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);
  localparam logic [4:0] ITER_SAT   = 5'd31;

  // The 4-bit layer index and 5-bit iteration counter bound the legal range.
  if (NUM_LAYERS < 1 || NUM_LAYERS > 16 || MAX_ITER < 1 || MAX_ITER > 31) begin : g_param_check
    $error("ldpc_iter_ctrl: NUM_LAYERS must be 1..16 and MAX_ITER 1..31");
  end

  logic [3:0] state_q, state_d;
  logic [3:0] layer_q, layer_d;
  logic [4:0] iter_q, iter_d;
  logic       decode_ok_q, decode_ok_d;
  logic       seq_err_q, seq_err_d;

  logic       start_q_unit_q;
  logic       rst_q_unit_q;
  logic       en_bubble_sort_q;
  logic       storage_q;
  logic       cu_start_q;
  logic       busy_q;
  logic       frame_done_q;

  // Next-state and datapath-register decisions for the frame sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    layer_d     = layer_q;
    iter_d      = iter_q;
    decode_ok_d = decode_ok_q;
    seq_err_d   = seq_err_q;

    if (bus.abort && state_q != S_IDLE) begin
      // Abort wins over everything; the frame ends silently.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.frame_start) begin
            state_d     = S_LOAD;
            decode_ok_d = 1'b0;
            seq_err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          layer_d = '0;
          iter_d  = '0;
          state_d = S_SORT;
        end
        S_SORT: begin
          if (bus.finish_bubble_sort) begin
            layer_d = '0;
            state_d = S_LAYER;
          end
        end
        S_LAYER: state_d = S_WAIT;
        S_WAIT: begin
          if (bus.cu_done) state_d = S_STORE;
        end
        S_STORE: begin
          if (layer_q == LAST_LAYER) begin
            layer_d = '0;
            state_d = S_ITER_END;
          end else begin
            layer_d = layer_q + 4'd1;
            state_d = S_LAYER;
          end
        end
        S_ITER_END: begin
          // The q-memory unit must agree that a full sweep of layers was
          // written; otherwise the two sequencers have drifted apart.
          if (bus.f_one_iteration) begin
            iter_d  = (iter_q == ITER_SAT) ? iter_q : iter_q + 5'd1;
            state_d = S_EVAL;
          end else begin
            seq_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_EVAL: begin
          if (bus.syndrome_ok || bus.last_iteration) begin
            decode_ok_d = bus.syndrome_ok;
            state_d     = S_DONE;
          end else begin
            state_d = S_LAYER;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer state, layer/iteration counters and sticky result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      iter_q      <= '0;
      decode_ok_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      state_q     <= state_d;
      layer_q     <= layer_d;
      iter_q      <= iter_d;
      decode_ok_q <= decode_ok_d;
      seq_err_q   <= seq_err_d;
    end
  end

  // Control strobes registered from the next state so they are glitch-free
  // and line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q_unit_q   <= 1'b0;
      rst_q_unit_q     <= 1'b1;
      en_bubble_sort_q <= 1'b0;
      storage_q        <= 1'b0;
      cu_start_q       <= 1'b0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      start_q_unit_q   <= (state_d == S_LOAD);
      rst_q_unit_q     <= (state_d != S_LOAD);
      en_bubble_sort_q <= (state_d == S_SORT);
      storage_q        <= (state_d == S_STORE);
      cu_start_q       <= (state_d == S_LAYER);
      busy_q           <= (state_d != S_IDLE);
      frame_done_q     <= (state_d == S_DONE);
    end
  end

  assign bus.start_q_unit   = start_q_unit_q;
  assign bus.rst_q_unit     = rst_q_unit_q;
  assign bus.en_bubble_sort = en_bubble_sort_q;
  assign bus.storage        = storage_q;
  assign bus.cu_start       = cu_start_q;
  assign bus.layer_idx      = layer_q;
  assign bus.iter_cnt       = iter_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.decode_ok      = decode_ok_q;
  assign bus.seq_err        = seq_err_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl. A behavioural q-memory / check-node
// model drives the status inputs; one compare process checks every strobe
// against frame-level expectations derived from the decoding rules.
`timescale 1ns/1ps
module tb_ldpc_iter_ctrl;

  localparam int NL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldpc_iter_ctrl_if bus ();

  ldpc_iter_ctrl #(.NUM_LAYERS(NL), .MAX_ITER(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Environment configuration for the current frame
  int cfg_syn_after  = 99;  // syndrome becomes ok after this many iterations
  int cfg_cap        = 30;  // q-memory raises last_iteration at this count
  int cfg_fix_d      = 2;   // cu_done delay after cu_start (0 = random 1..4)
  bit cfg_withhold   = 0;   // q-memory never reports a full iteration
  bit cfg_layer_pulse = 0;  // spurious cu_done during the cu_start cycle

  // Frame-level expectations
  int exp_iter, exp_stores, exp_gap;
  bit exp_dok, exp_serr;
  int launched = 0;

  // Environment model state
  int sort_n = 0, scnt = 0, qiters = 0, cu_cd = 0, cur_d = 2;

  // Environment model: sorter, check-node unit and q-memory unit
  always @(negedge clk) begin
    if (!rst_n) begin
      sort_n = 0; scnt = 0; qiters = 0; cu_cd = 0;
      bus.finish_bubble_sort = 1'b0;
      bus.f_one_iteration    = 1'b0;
      bus.last_iteration     = 1'b0;
      bus.cu_done            = 1'b0;
      bus.syndrome_ok        = 1'b0;
    end else begin
      if (bus.en_bubble_sort) sort_n++; else sort_n = 0;
      bus.finish_bubble_sort = (sort_n == 5);
      bus.cu_done = 1'b0;
      if (cu_cd > 0) begin
        cu_cd--;
        if (cu_cd == 0) bus.cu_done = 1'b1;
      end
      if (bus.cu_start) begin
        cur_d = (cfg_fix_d > 0) ? cfg_fix_d : int'($urandom_range(1, 4));
        cu_cd = cur_d;
        if (cfg_layer_pulse) bus.cu_done = 1'b1;
        bus.f_one_iteration = 1'b0;
      end
      if (!bus.rst_q_unit) begin
        scnt = 0; qiters = 0;
        bus.last_iteration  = 1'b0;
        bus.f_one_iteration = 1'b0;
      end
      if (bus.storage) begin
        scnt++;
        if (scnt == NL) begin
          scnt = 0;
          if (!cfg_withhold) begin
            qiters++;
            bus.f_one_iteration = 1'b1;
            bus.last_iteration  = (qiters >= cfg_cap);
          end
        end
      end
      bus.syndrome_ok = (qiters >= cfg_syn_after);
    end
  end

  // Compare process state
  int cyc = 0;
  always @(posedge clk) cyc++;
  int cu_cnt = 0, st_cnt = 0, last_cu_cyc = 0, last_st_cyc = 0;
  int en_run = 0, done_cnt = 0, start_cnt = 0;
  bit prev_done = 0;

  // Checks every meaningful DUT output on every cycle out of reset
  always @(negedge clk) begin
    if (!rst_n) begin
      cu_cnt = 0; st_cnt = 0; en_run = 0; prev_done = 0;
    end else begin
      check("strobe_onehot", 32'($countones({bus.start_q_unit, bus.en_bubble_sort,
                                              bus.cu_start, bus.storage}) <= 1), 1);
      check("rst_q_vs_start", bus.rst_q_unit, !bus.start_q_unit);
      if (bus.start_q_unit || bus.en_bubble_sort || bus.cu_start || bus.storage || bus.frame_done)
        check("busy_when_active", bus.busy, 1);
      if (bus.start_q_unit) begin
        start_cnt++; cu_cnt = 0; st_cnt = 0;
      end
      if (bus.en_bubble_sort) en_run++;
      else if (en_run > 0) begin
        check("sort_len", en_run, 5);
        en_run = 0;
      end
      if (bus.cu_start) begin
        check("cu_layer", bus.layer_idx, cu_cnt % NL);
        check("cu_iter", bus.iter_cnt, (cu_cnt / NL > 31) ? 31 : cu_cnt / NL);
        if (cu_cnt > 0) check("cu_gap", cyc - last_st_cyc, ((cu_cnt % NL) == 0) ? 3 : 1);
        last_cu_cyc = cyc;
        cu_cnt++;
      end
      if (bus.storage) begin
        check("st_layer", bus.layer_idx, st_cnt % NL);
        check("st_gap", cyc - last_cu_cyc, cur_d + 1);
        last_st_cyc = cyc;
        st_cnt++;
      end
      if (bus.frame_done) begin
        done_cnt++;
        check("done_iter", bus.iter_cnt, exp_iter);
        check("done_dok", bus.decode_ok, exp_dok);
        check("done_serr", bus.seq_err, exp_serr);
        check("done_stores", st_cnt, exp_stores);
        check("done_gap", cyc - last_st_cyc, exp_gap);
        prev_done = 1;
      end else if (prev_done) begin
        check("idle_after_done", bus.busy, 0);
        prev_done = 0;
      end
    end
  end

  // Sets the environment, derives the expected frame outcome, pulses frame_start
  task automatic launch(input int syn, input int cap, input bit wh, input int fixd, input bit lp);
    int t;
    cfg_syn_after = syn; cfg_cap = cap; cfg_withhold = wh;
    cfg_fix_d = fixd; cfg_layer_pulse = lp;
    t = wh ? 0 : ((syn < cap) ? syn : cap);
    exp_iter   = (t > 31) ? 31 : t;
    exp_dok    = !wh && (syn <= cap);
    exp_serr   = wh;
    exp_stores = wh ? NL : NL * t;
    exp_gap    = wh ? 2 : 3;
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    launched++;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_start_q"}, bus.start_q_unit, 0);
    check({name, "_rst_q"}, bus.rst_q_unit, 1);
    check({name, "_en_sort"}, bus.en_bubble_sort, 0);
    check({name, "_storage"}, bus.storage, 0);
    check({name, "_cu_start"}, bus.cu_start, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_frame_done"}, bus.frame_done, 0);
    check({name, "_layer"}, bus.layer_idx, 0);
    check({name, "_iter"}, bus.iter_cnt, 0);
    check({name, "_dok"}, bus.decode_ok, 0);
    check({name, "_serr"}, bus.seq_err, 0);
  endtask

  initial begin
    int n;
    int d0;
    bus.frame_start = 1'b0;
    bus.abort       = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Syndrome satisfied after the first iteration
    launch(1, 30, 0, 2, 0);
    wait_done("A");
    repeat (3) @(negedge clk);
    check("A_iter", bus.iter_cnt, 1);
    check("A_dok_held", bus.decode_ok, 1);
    check("A_serr", bus.seq_err, 0);
    check("A_stores", st_cnt, 16);

    // Never satisfied: terminated by the iteration cap
    launch(99, 30, 0, 2, 0);
    check("B_dok_cleared", bus.decode_ok, 0);
    wait_done("B");
    @(negedge clk);
    check("B_iter", bus.iter_cnt, 30);
    check("B_dok", bus.decode_ok, 0);
    check("B_stores", st_cnt, 480);

    // q-memory withholds f_one_iteration
    launch(99, 30, 1, 0, 0);
    wait_done("C");
    @(negedge clk);
    check("C_serr", bus.seq_err, 1);
    check("C_iter", bus.iter_cnt, 0);

    // Abort while waiting on layer 7
    launch(99, 30, 0, 2, 0);
    check("D_serr_cleared", bus.seq_err, 0);
    n = 0;
    while (!(bus.cu_start && bus.layer_idx == 4'd7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("D_found_layer7", bus.cu_start && bus.layer_idx == 4'd7, 1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("D_busy_after_abort", bus.busy, 0);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("D_no_done", done_cnt, d0);
    check("D_no_store", st_cnt, 7);

    // frame_start during SORT and cu_done during LAYER are ignored
    launch(1, 30, 0, 2, 1);
    @(negedge clk);
    check("E_in_sort", bus.en_bubble_sort, 1);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    wait_done("E");
    cfg_layer_pulse = 0;

    // Reset asserted in STORE of layer 3
    launch(99, 30, 0, 0, 0);
    n = 0;
    while (!(bus.storage && bus.layer_idx == 4'd3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("F_found_store3", bus.storage && bus.layer_idx == 4'd3, 1);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("F_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("F_no_done", done_cnt, d0);
    launch(2, 30, 0, 0, 0);
    wait_done("F_after");

    // Randomized frames: random syndrome point, cap and cu latency
    for (int i = 0; i < 4; i++) begin
      launch(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0, 0, 0);
      wait_done("R");
    end

    // Cap beyond 31: iteration counter saturates
    launch(99, 33, 0, 2, 0);
    wait_done("S");
    @(negedge clk);
    check("S_iter_sat", bus.iter_cnt, 31);

    repeat (5) @(negedge clk);
    check("start_count", start_cnt, launched);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
